// File: rtl/column_readout_ctrl.sv
// column_readout_ctrl
//   Column-end controller for a pixel-column readout chain.
//   - Free-running BCID and circular-buffer write address. Both are broadcast
//     down the chain together with the derived read address and an L1A flag.
//   - Accepted triggers queue their BCID in a small FIFO.
//   - Each queued event is drained from the chain and sent downstream as a
//     header / data... / trailer word stream on a valid/ready interface.
//
// Ports:
//   clk          40 MHz clock
//   reset        asynchronous, active-high reset
//   L1ADelay     trigger latency in clocks (low L1ADDRWIDTH bits used)
//   l1a          level-1 accept, one cycle per trigger
//   bcr          bunch-counter reset
//   dnData       head-of-chain hit word
//   dnHits       hits remaining in the chain (0..16 legal)
//   dnRead       pops one word from the chain at the clock edge
//   dnBCST       {l1aBit, rdAddr, wrAddr, bcid}
//   outData      {type[1:0], payload[45:0]}
//   outValid     outData valid
//   outReady     downstream accept
//   busy         event in progress or triggers queued
//   trigDropCnt  saturating count of triggers dropped on a full FIFO
module column_readout_ctrl #(
  parameter int L1ADDRWIDTH = 7,
  parameter int BCSTWIDTH   = 27,
  parameter int HIT_LATENCY = 4,
  parameter int TRIG_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8:0]           L1ADelay,
  input  logic                 l1a,
  input  logic                 bcr,
  input  logic [45:0]          dnData,
  input  logic [4:0]           dnHits,
  output logic                 dnRead,
  output logic [BCSTWIDTH-1:0] dnBCST,
  output logic [47:0]          outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 busy,
  output logic [7:0]           trigDropCnt
);

  localparam int          PTRW     = $clog2(TRIG_DEPTH);
  localparam logic [11:0] BCID_MAX = 12'd3563;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HEADER,
    ST_READ,
    ST_TRAILER
  } state_t;

  // ---------------------------------------------------------------------------
  // Broadcast counters
  // ---------------------------------------------------------------------------
  logic [L1ADDRWIDTH-1:0] wr_addr_reg;
  logic [L1ADDRWIDTH-1:0] rd_addr;
  logic [11:0]            bcid_reg;
  logic                   l1a_bit_reg;

  // Only the low address bits of the latency are meaningful.
  logic unused_delay_bits;
  assign unused_delay_bits = ^L1ADelay[8:L1ADDRWIDTH];

  assign rd_addr = wr_addr_reg - L1ADelay[L1ADDRWIDTH-1:0];
  assign dnBCST  = {l1a_bit_reg, rd_addr, wr_addr_reg, bcid_reg};

  // ---------------------------------------------------------------------------
  // Trigger FIFO
  // ---------------------------------------------------------------------------
  logic [11:0]     fifo_mem [TRIG_DEPTH];
  logic [PTRW-1:0] wr_ptr_reg;
  logic [PTRW-1:0] rd_ptr_reg;
  logic [PTRW:0]   fill_reg;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            drop;
  logic            pop;
  logic [7:0]      drop_cnt_reg;
  logic [7:0]      drop_cnt_next;

  // Full is judged on the registered fill level, so a trigger arriving in the
  // same cycle as a pop from a full FIFO is still dropped.
  assign fifo_full  = (fill_reg == (PTRW+1)'(TRIG_DEPTH));
  assign fifo_empty = (fill_reg == '0);
  assign push       = l1a && !fifo_full;
  assign drop       = l1a && fifo_full;

  assign drop_cnt_next = (drop && drop_cnt_reg != 8'hFF) ? drop_cnt_reg + 8'd1
                                                         : drop_cnt_reg;
  assign trigDropCnt   = drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bcid_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FSM
  // ---------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic [4:0]  hit_cnt_reg, hit_cnt_next;
  logic [4:0]  remain_reg, remain_next;
  logic        ovf_err_reg, ovf_err_next;
  logic [11:0] ev_bcid_reg;
  logic [7:0]  trl_drop_reg;

  assign pop  = (state_reg == ST_IDLE) && !fifo_empty;
  assign busy = (state_reg != ST_IDLE) || !fifo_empty;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    hit_cnt_next  = hit_cnt_reg;
    remain_next   = remain_reg;
    ovf_err_next  = ovf_err_reg;
    outValid      = 1'b0;
    outData       = '0;
    dnRead        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          wait_cnt_next = '0;
          state_next    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        wait_cnt_next = wait_cnt_reg + 4'd1;
        if (wait_cnt_reg == 4'(HIT_LATENCY - 1)) begin
          if (dnHits > 5'd16) begin
            hit_cnt_next = 5'd16;
            ovf_err_next = 1'b1;
          end else begin
            hit_cnt_next = dnHits;
          end
          state_next = ST_HEADER;
        end
      end

      ST_HEADER: begin
        outValid = 1'b1;
        outData  = {2'b10, 29'b0, hit_cnt_reg, ev_bcid_reg};
        if (outReady) begin
          remain_next = hit_cnt_reg;
          state_next  = (hit_cnt_reg != 5'd0) ? ST_READ : ST_TRAILER;
        end
      end

      ST_READ: begin
        outValid = 1'b1;
        outData  = {2'b01, dnData};
        // The chain is popped only on handshake, which keeps outData stable
        // while the consumer stalls.
        dnRead   = outReady;
        if (outReady) begin
          remain_next = remain_reg - 5'd1;
          if (remain_reg == 5'd1) begin
            state_next = ST_TRAILER;
          end
        end
      end

      ST_TRAILER: begin
        outValid = 1'b1;
        outData  = {2'b11, 20'b0, ovf_err_reg, trl_drop_reg, hit_cnt_reg, ev_bcid_reg};
        if (outReady) begin
          ovf_err_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_reg  <= '0;
      bcid_reg     <= '0;
      l1a_bit_reg  <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      drop_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      hit_cnt_reg  <= '0;
      remain_reg   <= '0;
      ovf_err_reg  <= 1'b0;
      ev_bcid_reg  <= '0;
      trl_drop_reg <= '0;
    end else begin
      wr_addr_reg <= wr_addr_reg + L1ADDRWIDTH'(1);

      if (bcr || bcid_reg == BCID_MAX) begin
        bcid_reg <= '0;
      end else begin
        bcid_reg <= bcid_reg + 12'd1;
      end

      l1a_bit_reg  <= push;
      drop_cnt_reg <= drop_cnt_next;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTRW'(1);
        ev_bcid_reg <= fifo_mem[rd_ptr_reg];
      end
      if (push && !pop) begin
        fill_reg <= fill_reg + (PTRW+1)'(1);
      end else if (pop && !push) begin
        fill_reg <= fill_reg - (PTRW+1)'(1);
      end

      wait_cnt_reg <= wait_cnt_next;
      hit_cnt_reg  <= hit_cnt_next;
      remain_reg   <= remain_next;
      ovf_err_reg  <= ovf_err_next;

      // Freeze the drop count shown in the trailer when the trailer starts,
      // so the word cannot change while the consumer stalls.
      if (state_next == ST_TRAILER && state_reg != ST_TRAILER) begin
        trl_drop_reg <= drop_cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_column_readout_ctrl.sv
`timescale 1ns/1ps
module tb_column_readout_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  L1ADelay = 9'd0;
  logic        l1a = 1'b0;
  logic        bcr = 1'b0;
  logic [45:0] dnData = '0;
  logic [4:0]  dnHits = '0;
  logic        dnRead;
  logic [26:0] dnBCST;
  logic [47:0] outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        busy;
  logic [7:0]  trigDropCnt;

  always #12.5 clk = ~clk;

  column_readout_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .L1ADelay    (L1ADelay),
    .l1a         (l1a),
    .bcr         (bcr),
    .dnData      (dnData),
    .dnHits      (dnHits),
    .dnRead      (dnRead),
    .dnBCST      (dnBCST),
    .outData     (outData),
    .outValid    (outValid),
    .outReady    (outReady),
    .busy        (busy),
    .trigDropCnt (trigDropCnt)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference counters for the broadcast fields.
  int m_bcid;
  int m_wr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_bcid = 0;
      m_wr   = 0;
    end else begin
      m_bcid = bcr ? 0 : ((m_bcid == 3563) ? 0 : m_bcid + 1);
      m_wr   = (m_wr + 1) % 128;
    end
  end

  // Pixel chain model: a queue of words; dnHits follows its size unless forced.
  logic [45:0] chain[$];
  bit          force_en = 1'b0;
  logic [4:0]  force_val = '0;
  bit          pop_now;
  always @(posedge clk) begin
    pop_now = dnRead;
    #2;
    if (pop_now && chain.size() > 0) chain.delete(0);
    dnData = (chain.size() > 0) ? chain[0] : '0;
    dnHits = force_en ? force_val : 5'(chain.size());
  end

  // Optional outReady toggling for back-pressure tests.
  bit toggle_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    if (toggle_mode) outReady = ~outReady;
  end

  // Output scoreboard and protocol monitor.
  logic [47:0] exp_q[$];
  int          rd_pulses = 0;
  bit          prev_stall = 1'b0;
  logic [47:0] prev_data = '0;
  always @(negedge clk) begin
    if (dnRead) begin
      rd_pulses++;
      check("dnread_qual", {45'b0, outReady, outData[47:46]}, 48'b101);
    end
    if (prev_stall) begin
      check("stall_valid", {47'b0, outValid}, 48'd1);
      check("stall_data", outData, prev_data);
    end
    if (outValid && outReady) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", {47'b0, outValid}, 48'd0);
      end else begin
        check("out_word", outData, exp_q[0]);
        exp_q.delete(0);
      end
    end
    prev_stall = outValid && !outReady;
    prev_data  = outData;
  end

  function automatic logic [47:0] hdr(input logic [4:0] h, input logic [11:0] b);
    return {2'b10, 29'b0, h, b};
  endfunction

  function automatic logic [47:0] trl(input logic o, input logic [7:0] d,
                                     input logic [4:0] h, input logic [11:0] b);
    return {2'b11, 20'b0, o, d, h, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    check("drain_queue", 48'(exp_q.size()), 48'd0);
    check("drain_busy", {47'b0, busy}, 48'd0);
  endtask

  // Load the chain with n words, optionally force dnHits, fire one trigger
  // and queue the expected header/data/trailer words.
  task automatic run_event(input int n, input bit frc, input logic [4:0] fval,
                           input logic [7:0] drop);
    logic [45:0] words[$];
    logic [4:0]  h;
    logic        ovf;
    logic [11:0] b;
    for (int i = 0; i < n; i++) begin
      logic [45:0] w;
      w = {14'($urandom), $urandom};
      words.push_back(w);
      chain.push_back(w);
    end
    force_en  = frc;
    force_val = fval;
    h   = frc ? ((fval > 5'd16) ? 5'd16 : fval) : 5'(n);
    ovf = frc && (fval > 5'd16);
    l1a = 1'b1;
    b   = 12'(m_bcid);
    tick();
    l1a = 1'b0;
    exp_q.push_back(hdr(h, b));
    for (int i = 0; i < int'(h); i++) exp_q.push_back({2'b01, words[i]});
    exp_q.push_back(trl(ovf, drop, h, b));
    wait_idle(300);
    force_en = 1'b0;
  endtask

  logic [11:0] bs[$];
  logic [11:0] b0;
  int          bit_pulses;

  initial begin
    // 1. Reset and free-running counters
    repeat (3) tick();
    check("rst_dnread", {47'b0, dnRead}, 48'd0);
    check("rst_outvalid", {47'b0, outValid}, 48'd0);
    check("rst_outdata", outData, 48'd0);
    check("rst_dropcnt", {40'b0, trigDropCnt}, 48'd0);
    check("rst_busy", {47'b0, busy}, 48'd0);
    check("rst_bcst", {21'b0, dnBCST}, 48'd0);
    reset = 1'b0;
    tick();
    check("bcid_first", {36'b0, dnBCST[11:0]}, 48'd1);
    check("wr_first", {41'b0, dnBCST[18:12]}, 48'd1);
    for (int i = 0; i < 200 && m_wr != 127; i++) tick();
    check("wr_max", {41'b0, dnBCST[18:12]}, 48'd127);
    tick();
    check("wr_wrap", {41'b0, dnBCST[18:12]}, 48'd0);
    for (int i = 0; i < 4000 && m_bcid != 3563; i++) begin
      tick();
      check("bcid_run", {36'b0, dnBCST[11:0]}, 48'(m_bcid));
    end
    check("bcid_max", {36'b0, dnBCST[11:0]}, 48'd3563);
    tick();
    check("bcid_wrap", {36'b0, dnBCST[11:0]}, 48'd0);
    repeat (5) tick();
    bcr = 1'b1;
    tick();
    bcr = 1'b0;
    check("bcr_zero", {36'b0, dnBCST[11:0]}, 48'd0);
    tick();
    check("bcr_next", {36'b0, dnBCST[11:0]}, 48'd1);

    // 2. Trigger broadcast and read address
    outReady = 1'b1;
    L1ADelay = 9'd10;
    for (int i = 0; i < 200 && m_wr != 5; i++) tick();
    l1a = 1'b1;
    b0  = 12'(m_bcid);
    tick();
    l1a = 1'b0;
    check("l1abit_set", {47'b0, dnBCST[26]}, 48'd1);
    check("l1a_wraddr", {41'b0, dnBCST[18:12]}, 48'd6);
    check("l1a_rdaddr", {41'b0, dnBCST[25:19]}, 48'd124);
    exp_q.push_back(hdr(5'd0, b0));
    exp_q.push_back(trl(1'b0, 8'd0, 5'd0, b0));
    tick();
    check("l1abit_clear", {47'b0, dnBCST[26]}, 48'd0);
    wait_idle(100);

    // 3. Three-word event, consumer always ready
    rd_pulses = 0;
    run_event(3, 1'b0, 5'd0, 8'd0);
    check("rd_pulses_3", 48'(rd_pulses), 48'd3);

    // 4. Same event with toggling back-pressure
    rd_pulses = 0;
    toggle_mode = 1'b1;
    run_event(3, 1'b0, 5'd0, 8'd0);
    toggle_mode = 1'b0;
    tick();
    outReady = 1'b1;
    check("rd_pulses_toggle", 48'(rd_pulses), 48'd3);

    // 5. Empty event, overflowing event, then ovfErr cleared
    rd_pulses = 0;
    run_event(0, 1'b0, 5'd0, 8'd0);
    check("rd_pulses_0", 48'(rd_pulses), 48'd0);
    run_event(16, 1'b1, 5'd20, 8'd0);
    run_event(0, 1'b0, 5'd0, 8'd0);

    // 6. Trigger FIFO overflow while the output is stalled
    outReady = 1'b0;
    l1a = 1'b1;
    b0  = 12'(m_bcid);
    tick();
    l1a = 1'b0;
    repeat (10) tick();
    check("busy_stalled", {47'b0, busy}, 48'd1);
    bit_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      l1a = 1'b1;
      bs.push_back(12'(m_bcid));
      tick();
      bit_pulses += int'(dnBCST[26]);
    end
    l1a = 1'b0;
    tick();
    bit_pulses += int'(dnBCST[26]);
    check("l1abit_pulses", 48'(bit_pulses), 48'd8);
    check("drop_count", {40'b0, trigDropCnt}, 48'd2);
    exp_q.push_back(hdr(5'd0, b0));
    exp_q.push_back(trl(1'b0, 8'd2, 5'd0, b0));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(hdr(5'd0, bs[i]));
      exp_q.push_back(trl(1'b0, 8'd2, 5'd0, bs[i]));
    end
    outReady = 1'b1;
    wait_idle(500);
    check("drop_count_end", {40'b0, trigDropCnt}, 48'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/column_readout_ctrl.md
Name: column_readout_ctrl

Overview:
Column-end controller that drives the downstream end of a pixel-column readout chain. It generates the broadcast word (BCID, circular-buffer write/read addresses and L1A) on dnBCST. It queues accepted triggers, then drains each event from the chain by reading dnHits/dnData and pulsing dnRead. Each event is emitted as a header/data/trailer stream on a valid/ready output toward the global readout.

Parameters:
L1ADDRWIDTH, 7, width of the pixel circular-buffer address.
BCSTWIDTH, 27, broadcast width; must equal 2*L1ADDRWIDTH+13.
HIT_LATENCY, 4, cycles waited after an event is dequeued before dnHits is sampled (2..15).
TRIG_DEPTH, 8, trigger FIFO depth (power of 2).

Ports:
clk  in  1  40 MHz clock.
reset  in  1  asynchronous, active-high reset.
L1ADelay  in  9  trigger latency in clocks; only the low L1ADDRWIDTH bits are used.
l1a  in  1  level-1 accept, one cycle per trigger.
bcr  in  1  bunch-counter reset.
dnData  in  46  head-of-chain hit word.
dnHits  in  5  hits remaining in the chain (0..16 legal).
dnRead  out  1  pops one word from the chain at the clock edge.
dnBCST  out  BCSTWIDTH  broadcast: [26] l1aBit, [25:19] rdAddr, [18:12] wrAddr, [11:0] bcid.
outData  out  48  {type[1:0], payload[45:0]}.
outValid  out  1  outData valid.
outReady  in  1  downstream accept.
busy  out  1  state != IDLE or trigger FIFO not empty.
trigDropCnt  out  8  dropped-trigger counter, saturating.

Behaviour:
- Reset: asynchronous, clears everything. wrAddr=0, bcid=0, l1aBit=0, FIFO empty, state=IDLE. While held and after release until events exist: dnRead=0, outValid=0, outData=0, trigDropCnt=0, busy=0.
- Counters:
  - wrAddr increments every cycle and wraps at 2^L1ADDRWIDTH-1 -> 0.
  - bcid increments every cycle and wraps 3563 -> 0.
  - bcr sampled high forces bcid=0 on the next cycle; bcr has priority over wrap.
- rdAddr = (wrAddr - L1ADelay[L1ADDRWIDTH-1:0]) mod 2^L1ADDRWIDTH, combinational from the registered wrAddr. All other dnBCST fields are register outputs.
- Trigger accept: l1a sampled high with FIFO not full sets l1aBit=1 for exactly the next cycle and pushes that cycle's dnBCST bcid into the FIFO.
- Trigger drop: l1a with FIFO full leaves l1aBit=0, pushes nothing, and increments trigDropCnt (saturates at 255).
- Simultaneous push and pop on a full FIFO counts as full: the trigger is dropped.
- FSM:
  - IDLE: FIFO not empty -> pop bcid into evBcid, clear waitCnt, go to WAIT.
  - WAIT: waitCnt increments each cycle. At waitCnt==HIT_LATENCY-1, sample dnHits into hitCnt. Values >16 are clamped to 16 and set ovfErr. Go to HEADER.
  - HEADER: outValid=1, outData={2'b10, 29'b0, hitCnt[4:0], evBcid[11:0]}. On outReady go to READ if hitCnt>0, else to TRAILER. Load remain=hitCnt.
  - READ: outValid=1, outData={2'b01, dnData}, dnRead=outReady, so a pop happens only on handshake. Each handshake decrements remain; the handshake with remain==1 goes to TRAILER.
  - TRAILER: outValid=1, outData={2'b11, 19'b0, ovfErr, trigDropCnt[7:0], hitCnt[4:0], evBcid[11:0]} (2+19+1+8+5+12=47; the remaining top payload bit is 0). On outReady clear ovfErr and go to IDLE.
- outData and outValid are stable while outValid && !outReady. In READ this holds because the chain is not popped without a handshake.
- dnRead is never asserted outside READ and never while outReady=0.
- Events are emitted strictly in trigger order, one at a time. Back-to-back events have no gap requirement beyond one IDLE cycle.
- Reset mid-event: the event is aborted with no trailer, and the queued triggers are discarded.

Test Plan:
1. Reset, then free-run -> dnBCST[11:0] counts 0,1,2,... and wraps 3563->0. wrAddr wraps 127->0. bcr pulse -> bcid=0 next cycle. All outputs 0 during reset.
2. L1ADelay=10, l1a sampled when wrAddr=5 -> next cycle l1aBit=1 for 1 cycle, wrAddr=6, rdAddr=124.
3. Chain model holding 3 words (A,B,C), outReady=1 -> header hitCnt=3 with the broadcast bcid, then data A,B,C, then trailer. dnRead high exactly 3 cycles.
4. Same event with outReady toggling 1/0 -> identical word sequence. dnRead never high when outReady=0. No word lost or duplicated.
5. Event with dnHits=0 -> header hitCnt=0 then trailer, no dnRead. dnHits=20 -> hitCnt=16, trailer ovfErr=1.
6. outReady=0, 10 consecutive l1a pulses -> 8 l1aBit pulses, trigDropCnt=2. After releasing outReady, 8 events appear in bcid order, then busy=0.
